// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus slave.
// Optional wait-state support is enabled with MEM_BUS_SLAVE_WAIT_STATE_EN.
package mem_bus_pkg;

  localparam int unsigned DefAddrW      = 20;
  localparam int unsigned DefDataW      = 16;
  localparam int unsigned DefDepth      = 1024;
  localparam int unsigned DefBaseAddr   = 32'h0000_0000;
  localparam int unsigned DefWaitCycles = 2;

  // One-hot bus-cycle states
  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StAddr  = 6'b000010,
    StWait  = 6'b000100,
    StRead  = 6'b001000,
    StWrite = 6'b010000,
    StDone  = 6'b100000
  } state_e;

  // Byte enables {hi, lo} for a cycle; a narrow bus always uses the single lane
  function automatic logic [1:0] lane_sel(input logic a0, input logic bhe_n, input logic wide);
    logic [1:0] lanes;
    if (!wide) begin
      lanes = 2'b01;
    end else begin
      case ({a0, bhe_n})
        2'b00:   lanes = 2'b11;
        2'b01:   lanes = 2'b01;
        2'b10:   lanes = 2'b10;
        default: lanes = 2'b00;
      endcase
    end
    return lanes;
  endfunction

endpackage

// File: rtl/mem_bus_slave_if.sv
// Bus-side signal bundle of the memory bus slave, with master and slave views.
interface mem_bus_slave_if
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);
  logic              ALE;
  logic              IOM;
  logic [ADDR_W-1:0] Address;
  logic              BHE_n;
  logic              RD;
  logic              WR;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              DOE;
  logic              READY;
  logic              HIT;

  modport master (
    output ALE, IOM, Address, BHE_n, RD, WR, DIN,
    input  DOUT, DOE, READY, HIT
  );

  modport slave (
    input  ALE, IOM, Address, BHE_n, RD, WR, DIN,
    output DOUT, DOE, READY, HIT
  );
endinterface

// File: rtl/mem_bus_ram.sv
// Word array with per-byte write enables and a registered read port.
module mem_bus_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  localparam int unsigned AddrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NumLanes = DATA_W / 8
) (
  input  logic                CLK,
  input  logic [AddrW-1:0]    addr,
  input  logic                re,
  input  logic [NumLanes-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and registered read; contents are deliberately not reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NumLanes; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_bus_slave.sv
// Memory-mapped bus slave: decodes a byte-address window, runs the bus-cycle FSM
// and maps byte lanes onto mem_bus_ram.
// Optional wait states: define MEM_BUS_SLAVE_WAIT_STATE_EN.
module mem_bus_slave
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned BASE_ADDR   = DefBaseAddr,
  parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
  input logic            CLK,
  input logic            RESET,
  mem_bus_slave_if.slave bus
);
  localparam int unsigned     NumLanes  = DATA_W / 8;
  localparam int unsigned     LaneShift = (DATA_W == 16) ? 1 : 0;
  localparam int unsigned     IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam longint unsigned WinLo     = 64'(BASE_ADDR);
  localparam longint unsigned WinSize   = 64'(DEPTH) * 64'(NumLanes);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                bhe_q, bhe_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                start, in_window;
  logic [IdxW-1:0]     word_idx;
  logic [NumLanes-1:0] lanes, rmask, ram_be;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata, dout;
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_dir_q, rd_dir_d;
`endif

  // Below-base addresses wrap to a huge offset, so one compare covers both edges
  assign in_window = (64'(bus.Address) - WinLo) < WinSize;
  assign start     = bus.ALE && !bus.IOM && in_window;
  assign word_idx  = IdxW'((64'(addr_q) - WinLo) >> LaneShift);
  assign lanes     = NumLanes'(lane_sel(addr_q[0], bhe_q, DATA_W == 16));
  // A cycle with no lanes enabled reads back the whole word
  assign rmask     = (lanes == '0) ? '1 : lanes;
  assign ram_re    = (state_d == StRead) && (state_q != StRead);

  // State and latched cycle attributes
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      addr_q  <= '0;
      bhe_q   <= 1'b1;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bhe_q   <= bhe_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
  // Wait-state counter and remembered direction
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q    <= '0;
      rd_dir_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_dir_q <= rd_dir_d;
    end
  end
`endif

  // Next-state logic, write-data capture and commit
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bhe_d   = bhe_q;
    wdata_d = wdata_q;
    ram_be  = '0;
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
    cnt_d    = cnt_q;
    rd_dir_d = rd_dir_q;
`endif
    if (!bus.WR && (state_q inside {StAddr, StWait, StWrite})) wdata_d = bus.DIN;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StAddr;
          addr_d  = bus.Address;
          bhe_d   = bus.BHE_n;
        end
      end
      StAddr: begin
        // Read takes priority when both strobes are low
        if (!bus.RD || !bus.WR) begin
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
          rd_dir_d = !bus.RD;
          if (WAIT_CYCLES != 0) begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = !bus.RD ? StRead : StWrite;
          end
`else
          state_d = !bus.RD ? StRead : StWrite;
`endif
        end
      end
      StWait: begin
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
        if (bus.ALE) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = rd_dir_q ? StRead : StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        state_d = StIdle;
`endif
      end
      StRead: begin
        if (bus.RD) state_d = StDone;
      end
      StWrite: begin
        if (bus.WR) begin
          ram_be  = lanes;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  mem_bus_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLK  (CLK),
    .addr (word_idx),
    .re   (ram_re),
    .be   (ram_be),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Read data gated to the selected lanes, zero outside READ
  always_comb begin
    dout = '0;
    if (state_q == StRead) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (rmask[i]) dout[8*i +: 8] = ram_rdata[8*i +: 8];
      end
    end
  end

  assign bus.DOUT = dout;
  assign bus.DOE  = (state_q == StRead);
  assign bus.HIT  = state_q inside {StAddr, StWait, StRead, StWrite};
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
  assign bus.READY = (state_q != StWait);
`else
  assign bus.READY = 1'b1;
`endif
endmodule

// File: tb/tb_mem_bus_slave.sv
// Self-checking bench for mem_bus_slave (16-bit data, base 0, 1024 words).
module tb_mem_bus_slave;
`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
  localparam int ExpWait = 3;
`else
  localparam int ExpWait = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mem_bus_slave_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  mem_bus_slave #(
    .ADDR_W     (20),
    .DATA_W     (16),
    .DEPTH      (1024),
    .BASE_ADDR  (0),
    .WAIT_CYCLES(3)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    bit          is_rd;
    logic [19:0] addr;
    logic        bhe;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  // Reference memory: word index -> contents
  logic [15:0] mdl [int];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Low byte is addressed when A0=0, high byte when BHE_n=0
  function automatic void model_write(input logic [19:0] a, input logic bhe, input logic [15:0] d);
    int          idx = int'(a) / 2;
    logic [15:0] w   = mdl.exists(idx) ? mdl[idx] : 16'h0000;
    if (!a[0]) w[7:0] = d[7:0];
    if (!bhe) w[15:8] = d[15:8];
    mdl[idx] = w;
  endfunction

  function automatic logic [15:0] model_read(input logic [19:0] a, input logic bhe);
    logic [15:0] w = mdl[int'(a) / 2];
    if (a[0] && bhe) return w;
    return {bhe ? 8'h00 : w[15:8], a[0] ? 8'h00 : w[7:0]};
  endfunction

  // One complete bus cycle, starting with ALE and ending in the DONE cycle
  task automatic run_cycle(input string tag, input bit is_rd, input bit both, input bit iom_v,
                           input logic [19:0] a, input logic bhe, input logic [15:0] d,
                           input bit exp_hit, input logic [15:0] exp_q);
    int n;
    bus.ALE = 1'b1; bus.IOM = iom_v; bus.Address = a; bus.BHE_n = bhe;
    bus.RD = 1'b1; bus.WR = 1'b1;
    tick();
    bus.ALE = 1'b0; bus.IOM = 1'b0;
    check({tag, ".hit"}, 32'(bus.HIT), 32'(exp_hit));
    bus.RD  = !(is_rd || both);
    bus.WR  = is_rd && !both;
    bus.DIN = d;
    tick();
    if (!exp_hit) begin
      check({tag, ".miss_doe"}, 32'(bus.DOE), 32'd0);
      check({tag, ".miss_ready"}, 32'(bus.READY), 32'd1);
      check({tag, ".miss_hit"}, 32'(bus.HIT), 32'd0);
      bus.RD = 1'b1; bus.WR = 1'b1;
      tick();
      return;
    end
    n = 0;
    while (bus.READY !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".waits"}, 32'(n), 32'(ExpWait));
    if (is_rd || both) begin
      check({tag, ".doe"}, 32'(bus.DOE), 32'd1);
      check({tag, ".dout"}, 32'(bus.DOUT), 32'(exp_q));
      bus.RD = 1'b1; bus.WR = 1'b1;
      tick();
    end else begin
      tick();
      bus.WR = 1'b1;
      tick();
    end
    check({tag, ".done_hit"}, 32'(bus.HIT), 32'd0);
    check({tag, ".done_doe"}, 32'(bus.DOE), 32'd0);
    check({tag, ".done_dout"}, 32'(bus.DOUT), 32'd0);
  endtask

  initial begin
    vec_t        vecs[13];
    int          n;
    logic [19:0] a;
    logic        bhe;
    logic [15:0] d;
    bit          rd;

    vecs[0]  = '{0, 20'h00010, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1, 20'h00010, 1'b0, 16'h0000, 16'hBEEF};
    vecs[2]  = '{0, 20'h00020, 1'b0, 16'h1234, 16'h0000};
    vecs[3]  = '{0, 20'h00021, 1'b0, 16'hABCD, 16'h0000};
    vecs[4]  = '{1, 20'h00020, 1'b0, 16'h0000, 16'hAB34};
    vecs[5]  = '{1, 20'h00021, 1'b0, 16'h0000, 16'hAB00};
    vecs[6]  = '{1, 20'h00020, 1'b1, 16'h0000, 16'h0034};
    vecs[7]  = '{0, 20'h00022, 1'b0, 16'h5555, 16'h0000};
    vecs[8]  = '{0, 20'h00023, 1'b1, 16'hFFFF, 16'h0000};
    vecs[9]  = '{1, 20'h00023, 1'b1, 16'h0000, 16'h5555};
    vecs[10] = '{0, 20'h00024, 1'b0, 16'h7700, 16'h0000};
    vecs[11] = '{0, 20'h00024, 1'b1, 16'h99A5, 16'h0000};
    vecs[12] = '{1, 20'h00024, 1'b0, 16'h0000, 16'h77A5};

    RESET = 1'b1;
    bus.ALE = 1'b0; bus.IOM = 1'b0; bus.Address = '0; bus.BHE_n = 1'b1;
    bus.RD = 1'b1; bus.WR = 1'b1; bus.DIN = '0;
    tick();
    tick();
    check("reset.dout", 32'(bus.DOUT), 32'd0);
    check("reset.doe", 32'(bus.DOE), 32'd0);
    check("reset.ready", 32'(bus.READY), 32'd1);
    check("reset.hit", 32'(bus.HIT), 32'd0);
    RESET = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].is_rd, 1'b0, 1'b0, vecs[i].addr, vecs[i].bhe,
                vecs[i].data, 1'b1, vecs[i].exp);
    end

    // Top word of the window, then decode misses must leave the array alone
    run_cycle("top_wr", 0, 0, 0, 20'h007FE, 1'b0, 16'h1357, 1'b1, 16'h0000);
    run_cycle("top_rd", 1, 0, 0, 20'h007FE, 1'b0, 16'h0000, 1'b1, 16'h1357);
    run_cycle("iom_wr", 0, 0, 1, 20'h00010, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_cycle("oob_wr", 0, 0, 0, 20'h00800, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_cycle("oob_rd", 1, 0, 0, 20'h00800, 1'b0, 16'h0000, 1'b0, 16'h0000);
    run_cycle("miss_chk", 1, 0, 0, 20'h00010, 1'b0, 16'h0000, 1'b1, 16'hBEEF);

    // RD and WR low together: read wins, nothing written
    run_cycle("rdwr", 1, 1, 0, 20'h00010, 1'b0, 16'hDEAD, 1'b1, 16'hBEEF);
    run_cycle("rdwr_chk", 1, 0, 0, 20'h00010, 1'b0, 16'h0000, 1'b1, 16'hBEEF);

    // Reset while WRITE holds WR low discards the write
    bus.ALE = 1'b1; bus.Address = 20'h00010; bus.BHE_n = 1'b0;
    tick();
    bus.ALE = 1'b0; bus.WR = 1'b0; bus.DIN = 16'h0BAD;
    tick();
    n = 0;
    while (bus.READY !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("rst_wr.hit_before", 32'(bus.HIT), 32'd1);
    RESET = 1'b1;
    #1;
    check("rst_wr.doe", 32'(bus.DOE), 32'd0);
    check("rst_wr.hit", 32'(bus.HIT), 32'd0);
    check("rst_wr.ready", 32'(bus.READY), 32'd1);
    check("rst_wr.dout", 32'(bus.DOUT), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    bus.WR = 1'b1;
    tick();
    tick();
    run_cycle("rst_wr_chk", 1, 0, 0, 20'h00010, 1'b0, 16'h0000, 1'b1, 16'hBEEF);

`ifdef MEM_BUS_SLAVE_WAIT_STATE_EN
    // ALE during wait states abandons the cycle
    bus.ALE = 1'b1; bus.Address = 20'h00010; bus.BHE_n = 1'b0;
    tick();
    bus.ALE = 1'b0; bus.RD = 1'b0;
    tick();
    check("abort.ready_low", 32'(bus.READY), 32'd0);
    bus.ALE = 1'b1; bus.Address = 20'h00900;
    tick();
    bus.ALE = 1'b0; bus.RD = 1'b1;
    check("abort.ready", 32'(bus.READY), 32'd1);
    check("abort.hit", 32'(bus.HIT), 32'd0);
    tick();
`endif

    // Randomized traffic over 16 words checked against the reference memory
    for (int w = 0; w < 16; w++) begin
      a = 20'h00100 + 20'(2 * w);
      d = 16'($urandom);
      run_cycle("rinit", 0, 0, 0, a, 1'b0, d, 1'b1, 16'h0000);
      model_write(a, 1'b0, d);
    end
    for (int k = 0; k < 150; k++) begin
      a   = 20'h00100 + 20'($urandom_range(0, 31));
      bhe = 1'($urandom);
      d   = 16'($urandom);
      rd  = 1'($urandom);
      if (rd) begin
        run_cycle($sformatf("rnd%0d", k), 1, 0, 0, a, bhe, d, 1'b1, model_read(a, bhe));
      end else begin
        run_cycle($sformatf("rnd%0d", k), 0, 0, 0, a, bhe, d, 1'b1, 16'h0000);
        model_write(a, bhe, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_slave.md
MEM_BUS_SLAVE -- requirements
Module: mem_bus_slave

Interface
REQ-001 Parameter ADDR_W, default 20, bus address width.
REQ-002 Parameter DATA_W, default 16, data width; only 8 or 16 are legal.
REQ-003 Parameter DEPTH, default 1024, number of DATA_W-bit words in the array.
REQ-004 Parameter BASE_ADDR, default 20'h00000, byte address of word 0.
REQ-005 Parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted per cycle (used only with WAIT_STATE_EN).
REQ-006 CLK  input  1  single clock; all state changes on rising edge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 ALE  input  1  address latch enable; high marks a new bus cycle.
REQ-009 IOM  input  1  1 = I/O cycle (ignored), 0 = memory cycle.
REQ-010 Address  input  ADDR_W  byte address, sampled while ALE high.
REQ-011 BHE_n  input  1  active-low high-byte enable; sampled with Address; ignored when DATA_W=8.
REQ-012 RD  input  1  active-low read strobe.
REQ-013 WR  input  1  active-low write strobe.
REQ-014 DIN  input  DATA_W  write data from bus master.
REQ-015 DOUT  output  DATA_W  read data; all-zero when DOE low.
REQ-016 DOE  output  1  high while DOUT is valid and to be driven onto the bus.
REQ-017 READY  output  1  high = slave ready; low during wait states.
REQ-018 HIT  output  1  high from address latch to end of cycle when the cycle targets this slave.

Function
REQ-019 FSM states: IDLE, ADDR, WAIT, READ, WRITE, DONE; one-hot encoded.
REQ-020 IDLE: ALE=1, IOM=0, Address in [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) -> latch Address/BHE_n, HIT=1, go ADDR; otherwise stay IDLE.
REQ-021 ADDR: RD=0 -> WAIT if wait count >0, else READ; else WR=0 -> WAIT if count >0, else WRITE; RD and WR both low -> read wins.
REQ-022 WAIT: READY=0, counter decrements each cycle; at zero go READ or WRITE per latched direction; ALE=1 in WAIT aborts to IDLE.
REQ-023 READ: DOUT registered from array at latched word on entry (1-cycle latency after READ entered), DOE=1; RD=1 -> DONE.
REQ-024 WRITE: DIN sampled every cycle WR=0; on first cycle WR=1, last sampled value committed to enabled lanes, then DONE.
REQ-025 DONE: DOE=0, HIT=0; ALE=1 -> IDLE evaluation same cycle (back-to-back cycles allowed).
REQ-026 Word index = (latched Address - BASE_ADDR) >> log2(DATA_W/8).
REQ-027 DATA_W=16 lanes: A0=0,BHE_n=0 word; A0=0,BHE_n=1 low byte; A0=1,BHE_n=0 high byte (data on DIN[15:8]); A0=1,BHE_n=1 no lanes, write dropped, read returns full word.
REQ-028 Byte read of one lane: other lane of DOUT driven zero.
REQ-029 I/O cycles and out-of-window addresses: no state change, DOE=0, READY=1.

Reset
REQ-030 RESET asserted (any time, including mid-cycle): state IDLE, DOUT=0, DOE=0, READY=1, HIT=0, wait counter 0.
REQ-031 Array contents not reset; an in-progress uncommitted write is discarded.

Configuration
REQ-032 Macro MEM_BUS_SLAVE_WAIT_STATE_EN: defined -> WAIT state and counter present, WAIT_CYCLES wait states per cycle; undefined -> WAIT never entered, READY tied 1, WAIT_CYCLES ignored.

Structure
REQ-033 Package mem_bus_pkg holds the state enum type, lane-select function and default parameter constants.
REQ-034 Array in sub-module mem_bus_ram (DEPTH x DATA_W, per-byte write enables, registered read port).

Verification
REQ-035 Word write/read, DATA_W=16, WAIT_CYCLES=0: write 16'hBEEF @ 20'h00010, then read -> DOUT=16'hBEEF, DOE=1 during READ.
REQ-036 Byte lanes: write 16'h1234 @ 20'h00020, then byte write 8'hAB @ 20'h00021 (BHE_n=0) -> word read 16'hAB34.
REQ-037 Wait states (macro defined, WAIT_CYCLES=3): READY low exactly 3 cycles after RD falls, then data valid.
REQ-038 Decode: IOM=1 or Address=BASE_ADDR+2*DEPTH -> HIT=0, DOE=0, array unchanged.
REQ-039 RESET pulsed while in WRITE with WR=0 -> outputs at reset values within same cycle; later read of that address returns prior contents.
REQ-040 RD and WR low together in ADDR -> read performed, no write committed.
